// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 matrix keypad emulator driving row lines from column strobes
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES   = 10000000,
  parameter int unsigned BOUNCE_CYCLES = 50000,
  parameter int unsigned BOUNCE_PERIOD = 5000,
  parameter int unsigned GAP_CYCLES    = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] fila,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_BOUNCE_IN  = 3'd1;
  localparam logic [2:0] S_HELD       = 3'd2;
  localparam logic [2:0] S_BOUNCE_OUT = 3'd3;
  localparam logic [2:0] S_GAP        = 3'd4;

  // Terminal counts; the bounce terminal is unused when bouncing is disabled.
  localparam logic [31:0] HOLD_TERM   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] GAP_TERM    = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] PERIOD_TERM = 32'(BOUNCE_PERIOD - 1);
  localparam logic [31:0] BOUNCE_TERM = (BOUNCE_CYCLES == 0) ? 32'd0 : 32'(BOUNCE_CYCLES - 1);
  localparam bit          NO_BOUNCE   = (BOUNCE_CYCLES == 0);

  logic [2:0]  state;
  logic [2:0]  state_d;
  logic [31:0] cnt;
  logic [31:0] pcnt;
  logic        contact;
  logic [3:0]  code_q;
  logic [3:0]  fila_d;
  logic        bouncing;

  assign key_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign bouncing  = (state == S_BOUNCE_IN) || (state == S_BOUNCE_OUT);

  // Next-state: each timed phase ends when its counter reaches the terminal count.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:       if (key_valid) state_d = NO_BOUNCE ? S_HELD : S_BOUNCE_IN;
      S_BOUNCE_IN:  if (cnt == BOUNCE_TERM) state_d = S_HELD;
      S_HELD:       if (cnt == HOLD_TERM) state_d = NO_BOUNCE ? S_GAP : S_BOUNCE_OUT;
      S_BOUNCE_OUT: if (cnt == BOUNCE_TERM) state_d = S_GAP;
      S_GAP:        if (cnt == GAP_TERM) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Row drive: only the latched row can go low, and only while its column is strobed.
  always_comb begin
    fila_d = 4'hF;
    if ((state != S_IDLE) && contact && !col[code_q[1:0]])
      fila_d[code_q[3:2]] = 1'b0;
  end

  // Sequencer state, phase counters, contact waveform, latched key and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 32'd0;
      pcnt    <= 32'd0;
      contact <= 1'b0;
      code_q  <= 4'd0;
      fila    <= 4'hF;
      done    <= 1'b0;
    end else begin
      state <= state_d;
      fila  <= fila_d;
      done  <= (state == S_GAP) && (state_d == S_IDLE);
      if ((state == S_IDLE) && key_valid)
        code_q <= key_code;
      if (state_d != state) begin
        // Every phase starts with fresh counters; contact opens closed on press phases.
        cnt     <= 32'd0;
        pcnt    <= 32'd0;
        contact <= (state_d == S_BOUNCE_IN) || (state_d == S_HELD);
      end else begin
        cnt <= cnt + 32'd1;
        if (bouncing) begin
          if (pcnt == PERIOD_TERM) begin
            pcnt    <= 32'd0;
            contact <= ~contact;
          end else begin
            pcnt <= pcnt + 32'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - self-checking bench for keypad_emulator
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid_a, key_valid_b;
  logic [3:0] fila_a, fila_b;
  logic       key_ready_a, key_ready_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_emulator #(.HOLD_CYCLES(8), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(1), .GAP_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .col(col), .fila(fila_a), .key_code(key_code),
    .key_valid(key_valid_a), .key_ready(key_ready_a), .busy(busy_a), .done(done_a)
  );

  keypad_emulator #(.HOLD_CYCLES(8), .BOUNCE_CYCLES(6), .BOUNCE_PERIOD(2), .GAP_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .col(col), .fila(fila_b), .key_code(key_code),
    .key_valid(key_valid_b), .key_ready(key_ready_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    logic [3:0] code;
    logic [3:0] colv;
    logic [3:0] exp_fila;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] col_for(input int mode, input int k);
    logic [3:0] v;
    v = 4'hF;
    if (mode == 0) v = 4'b1011;
    else if (mode == 1) begin
      case (k % 4)
        0: v = 4'b1110;
        1: v = 4'b1101;
        2: v = 4'b1011;
        default: v = 4'b0111;
      endcase
    end
    return v;
  endfunction

  // Expected fila[0] on dut_b for key 0 with column 0 strobed, cycle k after accept.
  function automatic logic exp_b0(input int k);
    int v;
    if (k >= 2 && k <= 7) begin
      v = k - 2;
      return (v == 2 || v == 3);
    end
    if (k >= 8 && k <= 15) return 1'b0;
    if (k >= 16 && k <= 21) begin
      v = k - 16;
      return !(v == 2 || v == 3);
    end
    return 1'b1;
  endfunction

  // Press key 0110 on dut_a (HOLD=8, GAP=4) with a column pattern and check every cycle.
  task automatic run_basic(input int mode, input string tag);
    logic [3:0] col_prev;
    logic [3:0] expf;
    col = col_for(mode, 0);
    key_code = 4'b0110;
    key_valid_a = 1'b1;
    chk($sformatf("%s ready c0", tag), key_ready_a, 1);
    tick();
    key_valid_a = 1'b0;
    key_code = 4'b1001;
    for (int k = 1; k <= 14; k++) begin
      col_prev = col;
      expf = ((k - 1) >= 1 && (k - 1) <= 8 && !col_prev[2]) ? 4'b1101 : 4'hF;
      chk($sformatf("%s fila c%0d", tag, k), fila_a, expf);
      chk($sformatf("%s busy c%0d", tag, k), busy_a, (k <= 12));
      chk($sformatf("%s done c%0d", tag, k), done_a, (k == 13));
      chk($sformatf("%s ready c%0d", tag, k), key_ready_a, (k >= 13));
      col = col_for(mode, k);
      if (k < 14) tick();
    end
    tick();
  endtask

  initial begin
    int accepts;
    int second_at;
    int dones;
    int first_done;
    vecs[0] = '{4'b0110, 4'b1011, 4'b1101};
    vecs[1] = '{4'b0110, 4'b1111, 4'b1111};
    vecs[2] = '{4'b0110, 4'b0000, 4'b1101};
    vecs[3] = '{4'b0110, 4'b1101, 4'b1111};
    vecs[4] = '{4'b1111, 4'b0111, 4'b0111};
    vecs[5] = '{4'b0000, 4'b1110, 4'b1110};
    vecs[6] = '{4'b1001, 4'b1101, 4'b1011};
    vecs[7] = '{4'b0011, 4'b0111, 4'b1110};

    reset = 1'b1;
    col = 4'hF;
    key_code = 4'h0;
    key_valid_a = 1'b0;
    key_valid_b = 1'b0;
    tick();
    tick();
    chk("reset fila", fila_a, 4'hF);
    chk("reset ready", key_ready_a, 1);
    chk("reset busy", busy_a, 0);
    chk("reset done", done_a, 0);
    reset = 1'b0;
    tick();

    run_basic(0, "basic");
    run_basic(1, "scan");
    run_basic(2, "nostrobe");

    // Table of key/column combinations: row drive observed mid-hold (cycle 5).
    for (int i = 0; i < 8; i++) begin
      col = vecs[i].colv;
      key_code = vecs[i].code;
      key_valid_a = 1'b1;
      tick();
      key_valid_a = 1'b0;
      repeat (4) tick();
      chk($sformatf("table%0d fila", i), fila_a, vecs[i].exp_fila);
      repeat (10) tick();
      chk($sformatf("table%0d idle", i), key_ready_a, 1);
    end
    tick();

    // Back-pressure: key_valid held for cycles 0..20.
    accepts = 0;
    second_at = -1;
    dones = 0;
    first_done = -1;
    col = 4'b0111;
    key_code = 4'hF;
    for (int c = 0; c <= 27; c++) begin
      key_valid_a = (c <= 20);
      if (done_a) begin
        dones++;
        if (first_done < 0) first_done = c;
      end
      if (key_valid_a && key_ready_a) begin
        accepts++;
        if (accepts == 2) second_at = c;
      end
      tick();
    end
    key_valid_a = 1'b0;
    chk("bp accepts", accepts, 2);
    chk("bp second accept cycle", second_at, 13);
    chk("bp done count", dones, 2);
    chk("bp first done cycle", first_done, 13);
    tick();

    // Bounce on press and release.
    col = 4'b1110;
    key_code = 4'h0;
    key_valid_b = 1'b1;
    tick();
    key_valid_b = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      chk($sformatf("bounce fila c%0d", k), fila_b, {3'b111, exp_b0(k)});
      chk($sformatf("bounce busy c%0d", k), busy_b, (k <= 24));
      chk($sformatf("bounce done c%0d", k), done_b, (k == 25));
      tick();
    end

    // Reset mid-hold.
    col = 4'b1011;
    key_code = 4'b0110;
    key_valid_a = 1'b1;
    tick();
    key_valid_a = 1'b0;
    repeat (4) tick();
    chk("midreset fila before", fila_a, 4'b1101);
    reset = 1'b1;
    #1;
    chk("midreset fila async", fila_a, 4'hF);
    chk("midreset ready async", key_ready_a, 1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("midreset busy", busy_a, 0);
    chk("midreset ready", key_ready_a, 1);
    dones = 0;
    for (int k = 0; k < 14; k++) begin
      if (done_a) dones++;
      tick();
    end
    chk("midreset no done", dones, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
